// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared types and the March C- element table for the SRAM BIST
// Provides: state_t (sequencer states), op_t (bus operation), elem_t/ELEMS
// (direction, two-op flag and per-op polarity per element), cmp_tag_t (compare entry).
package sram_bist_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  // bit 1 = write, bit 0 = complement background
  typedef enum logic [1:0] {RD_P = 2'b00, RD_Q = 2'b01, WR_P = 2'b10, WR_Q = 2'b11} op_t;
  typedef struct packed {
    logic down;
    logic two;
    op_t  op0;
    op_t  op1;
  } elem_t;
  typedef struct packed {
    logic       valid;
    logic [2:0] elem;
    logic       inv;
  } cmp_tag_t;
  // entries 6/7 never run; they mirror E5 so the table is fully indexable
  localparam elem_t [0:7] ELEMS = '{
    '{1'b0, 1'b0, WR_P, WR_P},
    '{1'b0, 1'b1, RD_P, WR_Q},
    '{1'b0, 1'b1, RD_Q, WR_P},
    '{1'b1, 1'b1, RD_P, WR_Q},
    '{1'b1, 1'b1, RD_Q, WR_P},
    '{1'b0, 1'b0, RD_P, RD_P},
    '{1'b0, 1'b0, RD_P, RD_P},
    '{1'b0, 1'b0, RD_P, RD_P}
  };
endpackage

// File: rtl/sram_bist_cmp.sv
// sram_bist_cmp: read-compare pipeline, error counter and first-failure capture
// In: read tag/address of the op on the bus, latched sel/pattern, flattened dout0,
// flush (drop in-flight compares), clr (clear results). Out: hit, err_count, fail_*.
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int N_MACROS = 16,
  parameter int READ_LAT = 1,
  parameter int ERR_W    = 16,
  parameter int SEL_W    = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         clr,
  input  logic                         rd_vld,
  input  logic [2:0]                   rd_elem,
  input  logic                         rd_inv,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic [SEL_W-1:0]             sel,
  input  logic [DATA_W-1:0]            pat,
  input  logic [N_MACROS*DATA_W-1:0]   dout0,
  output logic                         hit,
  output logic [ERR_W-1:0]             err_count,
  output logic                         fail_valid,
  output logic [ADDR_W-1:0]            fail_addr,
  output logic [DATA_W-1:0]            fail_data,
  output logic [2:0]                   fail_elem
);
  cmp_tag_t          tag [READ_LAT];
  logic [ADDR_W-1:0] adr [READ_LAT];
  logic [DATA_W-1:0] slice;
  // an out-of-range macro reads as zero so the test is guaranteed to fail
  assign slice = int'(sel) < N_MACROS ? dout0[int'(sel)*DATA_W +: DATA_W] : '0;
  assign hit = tag[READ_LAT-1].valid && !flush &&
               slice != (tag[READ_LAT-1].inv ? ~pat : pat);
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      for (int i = 0; i < READ_LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= '{valid: rd_vld, elem: rd_elem, inv: rd_inv};
      for (int i = 1; i < READ_LAT; i++) tag[i] <= tag[i-1];
    end
  end
  always_ff @(posedge clk) begin
    adr[0] <= rd_addr;
    for (int i = 1; i < READ_LAT; i++) adr[i] <= adr[i-1];
  end
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_elem  <= '0;
    end else if (hit) begin
      err_count <= err_count + ERR_W'(!(&err_count));
      if (!fail_valid) begin
        fail_valid <= 1'b1;
        fail_addr  <= adr[READ_LAT-1];
        fail_data  <= slice;
        fail_elem  <= tag[READ_LAT-1].elem;
      end
    end
  end
endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- BIST sequencer driving the shared OpenRAM port-0 bus
// In: clk, resetn, start, abort, macro_sel, depth_m1, pattern, dout0.
// Out: addr0/din0/web0/wmask0/csb0 (SRAM bus), busy, done, pass, err_count, fail_*.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int WMASK_W  = 4,
  parameter int N_MACROS = 16,
  parameter int READ_LAT = 1,
  parameter int ERR_W    = 16,
  localparam int SEL_W   = N_MACROS > 1 ? $clog2(N_MACROS) : 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [SEL_W-1:0]           macro_sel,
  input  logic [ADDR_W-1:0]          depth_m1,
  input  logic [DATA_W-1:0]          pattern,
  input  logic [N_MACROS*DATA_W-1:0] dout0,
  output logic [ADDR_W-1:0]          addr0,
  output logic [DATA_W-1:0]          din0,
  output logic                       web0,
  output logic [WMASK_W-1:0]         wmask0,
  output logic [N_MACROS-1:0]        csb0,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [ERR_W-1:0]           err_count,
  output logic                       fail_valid,
  output logic [ADDR_W-1:0]          fail_addr,
  output logic [DATA_W-1:0]          fail_data,
  output logic [2:0]                 fail_elem
);
  state_t              state;
  logic [SEL_W-1:0]    sel;
  logic [ADDR_W-1:0]   dm1;
  logic [DATA_W-1:0]   pat;
  logic [2:0]          elem;
  logic                ph;
  logic                rd_vld;
  logic                rd_inv;
  logic [1:0]          dcnt;
  logic                hit;
  logic                start_ok;
  logic                step_in;
  logic                last_addr;
  logic                fin;
  logic                drv;
  logic [2:0]          n_elem;
  logic [ADDR_W-1:0]   n_addr;
  logic                n_ph;
  op_t                 n_op;
  logic [SEL_W-1:0]    n_sel;
  logic [DATA_W-1:0]   n_pat;
  logic [N_MACROS-1:0] n_csb;
  // addr0/elem/ph always hold the op currently on the bus; next op is derived from them
  always_comb begin
    start_ok  = start && (state == S_IDLE || state == S_DONE);
    step_in   = ELEMS[elem].two && !ph;
    last_addr = ELEMS[elem].down ? (addr0 == '0) : (addr0 == dm1);
    fin       = state == S_RUN && !step_in && last_addr && elem == 3'd5;
    drv       = start_ok || (state == S_RUN && !fin);
    n_elem    = start_ok ? 3'd0 : (step_in || !last_addr) ? elem : elem + 3'd1;
    n_addr    = start_ok ? '0 : step_in ? addr0 :
                !last_addr ? (ELEMS[elem].down ? addr0 - ADDR_W'(1) : addr0 + ADDR_W'(1)) :
                ELEMS[n_elem].down ? dm1 : '0;
    n_ph      = !start_ok && step_in;
    n_op      = n_ph ? ELEMS[n_elem].op1 : ELEMS[n_elem].op0;
    n_sel     = start_ok ? macro_sel : sel;
    n_pat     = start_ok ? pattern : pat;
    // a select beyond the array shifts the one out, leaving every csb high
    n_csb     = ~(N_MACROS'(1) << n_sel);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      sel    <= '0;
      dm1    <= '0;
      pat    <= '0;
      elem   <= '0;
      ph     <= 1'b0;
      dcnt   <= '0;
      rd_vld <= 1'b0;
      rd_inv <= 1'b0;
      addr0  <= '0;
      din0   <= '0;
      web0   <= 1'b1;
      wmask0 <= '0;
      csb0   <= '1;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else if (abort) begin
      state  <= S_IDLE;
      csb0   <= '1;
      web0   <= 1'b1;
      wmask0 <= '0;
      rd_vld <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (start_ok) begin
        sel   <= macro_sel;
        dm1   <= depth_m1;
        pat   <= pattern;
        state <= S_RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
        pass  <= 1'b0;
      end
      if (drv) begin
        elem   <= n_elem;
        ph     <= n_ph;
        addr0  <= n_addr;
        din0   <= n_op[0] ? ~n_pat : n_pat;
        web0   <= !n_op[1];
        wmask0 <= {WMASK_W{n_op[1]}};
        csb0   <= n_csb;
        rd_vld <= !n_op[1];
        rd_inv <= n_op[0];
      end else begin
        csb0   <= '1;
        web0   <= 1'b1;
        wmask0 <= '0;
        rd_vld <= 1'b0;
      end
      if (fin) begin
        state <= S_DRAIN;
        dcnt  <= '0;
      end
      if (state == S_DRAIN) begin
        dcnt <= dcnt + 2'd1;
        if (dcnt == 2'(READ_LAT - 1)) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          // the last compare lands on this same edge
          pass  <= err_count == '0 && !hit;
        end
      end
    end
  end
  sram_bist_cmp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_MACROS(N_MACROS),
    .READ_LAT(READ_LAT), .ERR_W(ERR_W), .SEL_W(SEL_W)
  ) u_cmp (
    .clk(clk),
    .resetn(resetn),
    .flush(abort),
    .clr(start_ok && !abort),
    .rd_vld(rd_vld),
    .rd_elem(elem),
    .rd_inv(rd_inv),
    .rd_addr(addr0),
    .sel(sel),
    .pat(pat),
    .dout0(dout0),
    .hit(hit),
    .err_count(err_count),
    .fail_valid(fail_valid),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .fail_elem(fail_elem)
  );
endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Parametrised built-in self-test sequencer for the OpenRAM macro array. It drives the shared port-0 control/data bus (addr0/din0/web0/wmask0) plus one csb0 per macro.
- Runs a March C- test on one selected macro. Compares read data against the expected background, counts mismatches and captures the first failure.
- Sits beside the testchip control logic. Turns manual scan-load read/write into a single-command test over N_MACROS macros of any width and depth.

Parameters:
ADDR_W, 10, width of addr0 and depth_m1
DATA_W, 32, width of din0 and of each macro's dout slice
WMASK_W, 4, width of wmask0; all ones during writes
N_MACROS, 16, number of macros (csb0 bits, dout0 slices)
READ_LAT, 1, cycles from the read-issue edge to the edge where dout is compared (1..3)
ERR_W, 16, width of err_count

Ports:
clk  in  1  single clock for BIST and SRAMs
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse that begins a test when idle
abort  in  1  stop the running test, return to idle
macro_sel  in  $clog2(N_MACROS)  macro under test, sampled at start
depth_m1  in  ADDR_W  last address tested (depth-1), sampled at start
pattern  in  DATA_W  background "0" value; "1" = ~pattern, sampled at start
dout0  in  N_MACROS*DATA_W  flattened macro read data, slice i = macro i
addr0  out  ADDR_W  shared address
din0  out  DATA_W  shared write data
web0  out  1  write enable, active low
wmask0  out  WMASK_W  write byte mask
csb0  out  N_MACROS  per-macro chip select, active low
busy  out  1  test in progress (includes drain)
done  out  1  held high after completion until next start
pass  out  1  valid when done: err_count==0
err_count  out  ERR_W  mismatching reads, saturating at all ones
fail_valid  out  1  first failure captured
fail_addr  out  ADDR_W  address of first mismatch
fail_data  out  DATA_W  dout read at first mismatch
fail_elem  out  3  march element (0..5) of first mismatch

Behaviour:
- Reset (resetn low at a clk edge): csb0 all 1, web0=1, wmask0=0, addr0=0, din0=0. Also busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_addr=0, fail_data=0, fail_elem=0. Reset mid-test deasserts all csb0 on the same edge.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch macro_sel, depth_m1, pattern. Clear err_count and fail_*; done=0, busy=1; go to RUN.
- start while busy: ignored.
- March elements, with P=pattern and Q=~pattern:
  - E0 up: wP
  - E1 up: rP, wQ
  - E2 up: rQ, wP
  - E3 down: rP, wQ
  - E4 down: rQ, wP
  - E5 up: rP
- Up elements run address 0 to depth_m1; down elements run depth_m1 to 0.
- One op per cycle: E0 and E5 take 1 cycle per address; E1-E4 take 2 cycles per address (read then write, same address).
- Bus drive in RUN:
  - Every op: only csb0[sel]=0.
  - Read: web0=1, wmask0=0.
  - Write: web0=0, wmask0 all ones, din0=P or Q.
- Idle or drain: all csb0=1, web0=1.
- Compare pipeline:
  - Each read pushes {valid, addr, elem, expected} into a READ_LAT-deep shift register.
  - At the output stage, slice dout0[sel*DATA_W +: DATA_W] is compared with expected.
  - On mismatch, err_count increments (saturating). If fail_valid=0, capture fail_addr/fail_data/fail_elem and set fail_valid.
- After the last E5 read, RUN moves to DRAIN for READ_LAT cycles. Then go to DONE: busy=0, done=1, pass=(err_count==0), counting the final compare.
- Total busy cycles = 10*D + READ_LAT, where D = depth_m1+1.
- depth_m1=0: single address, 10 ops.
- Address wrap: the down counter stops at 0 and never wraps; the up counter stops at depth_m1.
- abort (priority over start): on the next edge all csb0=1, state goes to IDLE, busy=0, done=0, and in-flight compares are discarded. err_count and fail_* keep their values.
- macro_sel >= N_MACROS: no csb asserted, compare slice forced to 0, so the test fails.

Decomposition:
- Shared package sram_bist_pkg holds:
  - state enum
  - element table (direction, op count, read/write polarity per op)
  - op enum (RD_P, RD_Q, WR_P, WR_Q)
  - compare-pipeline entry struct
- One sub-module: sram_bist_cmp, holding the READ_LAT shift register, slice mux, error counter and first-fail capture.

Test Plan:
- Behavioural SRAM model, D=4, pattern=0x0000_00FF, fault-free -> busy for 41 cycles (READ_LAT=1), then done=1, pass=1, err_count=0, fail_valid=0.
- Bit 3 at address 2 stuck-at-1, pattern=0 -> first failure in E1: fail_addr=2, fail_elem=1, fail_data=0x0000_0008, err_count=3 (E1, E3, E5), pass=0.
- depth_m1=0, macro_sel=5 -> exactly 10 cycles with csb0=16'hFFDF and all other csb bits high; done after READ_LAT.
- abort asserted at cycle 7 of a D=4 run -> all csb0 high next cycle, busy=0, done=0. A new start then completes normally with pass=1.
- start pulsed again at cycle 5 of a run -> ignored, and total latency is unchanged at 41.
- resetn low for one cycle mid-run -> all outputs take their reset values on that edge, and no SRAM op is issued afterwards.
